// File: rtl/seven_seg_pkg.sv
// Shared constants, pattern type and scan FSM state for the 6-digit seven-segment scan driver.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIG_W      = 3;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_ZERO = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b1111111;

  localparam logic [DIG_W-1:0] DIG_HUNDREDTHS = 3'd0;
  localparam logic [DIG_W-1:0] DIG_TENTHS     = 3'd1;
  localparam logic [DIG_W-1:0] DIG_ONE_SEC    = 3'd2;
  localparam logic [DIG_W-1:0] DIG_TEN_SECS   = 3'd3;
  localparam logic [DIG_W-1:0] DIG_ONE_MIN    = 3'd4;
  localparam logic [DIG_W-1:0] DIG_TEN_MINS   = 3'd5;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Digit scan order 0..5, wrapping back to the hundredths digit.
  function automatic logic [DIG_W-1:0] next_digit(input logic [DIG_W-1:0] d);
    return (d == DIG_TEN_MINS) ? DIG_HUNDREDTHS : d + DIG_W'(1);
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_timer.sv
// Slot timer: BLANK/SHOW FSM, in-slot cycle counter and digit counter; flags the frame snapshot.
module scan_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 10,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  output scan_state_e      o_state,
  output logic [DIG_W-1:0] o_digit,
  output logic             o_snap_c
);

  localparam int unsigned      CNT_W      = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DWELL_CYCLES - BLANK_CYCLES - 1);

  scan_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIG_W-1:0] r_digit, w_digit_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_digit <= DIG_HUNDREDTHS;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_digit <= w_digit_nxt;
    end
  end

  // Disable parks the scan at the start of a blank slot for digit 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_digit_nxt = r_digit;
    o_snap_c    = 1'b0;
    if (!i_enable) begin
      w_state_nxt = BLANK;
      w_cnt_nxt   = '0;
      w_digit_nxt = DIG_HUNDREDTHS;
    end else begin
      case (r_state)
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = '0;
            o_snap_c    = (r_digit == DIG_HUNDREDTHS);
          end
        end
        SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            w_digit_nxt = next_digit(r_digit);
          end
        end
        default: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_digit = r_digit;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 6-digit common-anode driver with per-frame pattern snapshot.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero ten_mins/one_min digits.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DIGIT_HZ     = 1000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter logic [5:0]  DP_MASK      = 6'b010100
) (
  input  logic       CLK_50MHz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] hundredths_seven_seg,
  input  logic [6:0] tenths_seven_seg,
  input  logic [6:0] one_sec_seven_seg,
  input  logic [6:0] ten_secs_seven_seg,
  input  logic [6:0] one_min_seven_seg,
  input  logic [6:0] ten_mins_seven_seg,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       frame_tick
);

  localparam int unsigned DWELL_CYCLES = CLK_HZ / DIGIT_HZ;

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank
    $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DWELL_CYCLES");
  end

  scan_state_e      w_state;
  logic [DIG_W-1:0] w_digit;
  logic             w_snap;
  logic             w_suppress;
  seg_t             w_in     [NUM_DIGITS];
  seg_t             r_shadow [NUM_DIGITS];
  logic [5:0]       r_an_n, w_an_nxt;
  seg_t             r_seg_n, w_seg_nxt;
  logic             r_dp_n, w_dp_nxt;
  logic             r_frame_tick;

  scan_slot_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk     (CLK_50MHz),
    .rst_n   (reset_n),
    .i_enable(enable),
    .o_state (w_state),
    .o_digit (w_digit),
    .o_snap_c(w_snap)
  );

  assign w_in[0] = hundredths_seven_seg;
  assign w_in[1] = tenths_seven_seg;
  assign w_in[2] = one_sec_seven_seg;
  assign w_in[3] = ten_secs_seven_seg;
  assign w_in[4] = one_min_seven_seg;
  assign w_in[5] = ten_mins_seven_seg;

`ifdef LEADING_ZERO_BLANK_EN
  assign w_suppress =
      ((w_digit == DIG_TEN_MINS) && (r_shadow[5] == SEG_ZERO)) ||
      ((w_digit == DIG_ONE_MIN)  && (r_shadow[5] == SEG_ZERO) && (r_shadow[4] == SEG_ZERO));
`else
  assign w_suppress = 1'b0;
`endif

  // Shadow patterns only change at the start of a frame so a frame never tears.
  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= SEG_OFF;
    end else if (w_snap) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= w_in[i];
    end
  end

  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if (enable && (w_state == SHOW)) begin
      w_seg_nxt = r_shadow[w_digit];
      if (!w_suppress) begin
        w_an_nxt[w_digit] = 1'b0;
        w_dp_nxt          = ~DP_MASK[w_digit];
      end
    end
  end

  always_ff @(posedge CLK_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_an_n       <= '1;
      r_seg_n      <= SEG_OFF;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an_n       <= w_an_nxt;
      r_seg_n      <= w_seg_nxt;
      r_dp_n       <= w_dp_nxt;
      r_frame_tick <= w_snap;
    end
  end

  assign an_n       = r_an_n;
  assign seg_n      = r_seg_n;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver against a slot-arithmetic reference model.
module tb_seven_seg_scan_driver;

  localparam int DWELL = 10;
  localparam int BLANKC = 2;
  localparam int FRAME = 6 * DWELL;
  localparam logic [5:0] DPM = 6'b010100;
  localparam logic [6:0] ZERO = 7'b1000000;
  localparam logic [6:0] OFF = 7'b1111111;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b1;
  logic [6:0] in_d [6];
  logic [6:0] seg_n;
  logic dp_n;
  logic [5:0] an_n;
  logic frame_tick;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(2), .DP_MASK(DPM)
  ) dut (
    .CLK_50MHz(clk), .reset_n(reset_n), .enable(enable),
    .hundredths_seven_seg(in_d[0]), .tenths_seven_seg(in_d[1]),
    .one_sec_seven_seg(in_d[2]), .ten_secs_seven_seg(in_d[3]),
    .one_min_seven_seg(in_d[4]), .ten_mins_seven_seg(in_d[5]),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: position in the frame is a plain cycle count since (re)start.
  int m_t;
  logic [6:0] m_sh [6];
  logic [5:0] m_an;
  logic [6:0] m_seg;
  logic m_dp, m_tick;
  int m_dig;
  bit m_show, m_sup;

  always_comb begin
    m_dig = (m_t / DWELL) % 6;
    m_show = (m_t % DWELL) >= BLANKC;
    m_sup = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    m_sup = (m_dig == 5 && m_sh[5] == ZERO) || (m_dig == 4 && m_sh[5] == ZERO && m_sh[4] == ZERO);
`endif
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t <= 0; m_an <= '1; m_seg <= OFF; m_dp <= 1'b1; m_tick <= 1'b0;
      for (int i = 0; i < 6; i++) m_sh[i] <= OFF;
    end else if (!enable) begin
      m_t <= 0; m_an <= '1; m_seg <= OFF; m_dp <= 1'b1; m_tick <= 1'b0;
    end else begin
      m_t <= (m_t + 1) % FRAME;
      m_tick <= (m_t == BLANKC - 1);
      if (m_t == BLANKC - 1) for (int i = 0; i < 6; i++) m_sh[i] <= in_d[i];
      m_an <= '1; m_seg <= OFF; m_dp <= 1'b1;
      if (m_show) begin
        m_seg <= m_sh[m_dig];
        if (!m_sup) begin
          m_an <= ~(6'b000001 << m_dig);
          m_dp <= ~DPM[m_dig];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("an_n", 16'(an_n), 16'(m_an));
      chk("seg_n", 16'(seg_n), 16'(m_seg));
      chk("dp_n", 16'(dp_n), 16'(m_dp));
      chk("frame_tick", 16'(frame_tick), 16'(m_tick));
      chk("one_anode_max", 16'($countones(~an_n) <= 1), 16'(1));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pattern();
    in_d[0] = 7'b1000000; in_d[1] = 7'b1111001; in_d[2] = 7'b0100100;
    in_d[3] = 7'b0110000; in_d[4] = 7'b0011001; in_d[5] = 7'b0010010;
  endtask

  task automatic restart();
    @(negedge clk); #2 reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  // Runs whole frames after a restart and reports whether anodes 4/5 were ever driven.
  task automatic watch_lead(input int n, output bit seen4, output bit seen5);
    seen4 = 1'b0; seen5 = 1'b0;
    repeat (n) begin
      adv(1);
      if (!an_n[4]) seen4 = 1'b1;
      if (!an_n[5]) seen5 = 1'b1;
    end
  endtask

  int hold;
  bit s4, s5;

  initial begin
    set_pattern();
    enable = 1'b1;
    #1 reset_n = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_an", 16'(an_n), 16'h3f);
    chk("rst_seg", 16'(seg_n), 16'h7f);
    chk("rst_dp", 16'(dp_n), 16'(1));
    chk("rst_tick", 16'(frame_tick), 16'(0));
    reset_n = 1'b1;

    adv(1); chk("e1_an", 16'(an_n), 16'h3f); chk("model_t", 16'(m_t), 16'(1));
    adv(1); chk("e2_tick", 16'(frame_tick), 16'(1)); chk("e2_an", 16'(an_n), 16'h3f);
    adv(1); chk("e3_an", 16'(an_n), 16'(6'b111110)); chk("e3_seg", 16'(seg_n), 16'(7'b1000000));
    chk("e3_dp", 16'(dp_n), 16'(1)); chk("e3_tick", 16'(frame_tick), 16'(0));
    adv(7); chk("e10_an", 16'(an_n), 16'(6'b111110));
    adv(1); chk("e11_an", 16'(an_n), 16'h3f);
    adv(12); chk("e23_an", 16'(an_n), 16'(6'b111011)); chk("e23_seg", 16'(seg_n), 16'(7'b0100100));
    chk("e23_dp", 16'(dp_n), 16'(0));
    adv(30); chk("e53_an", 16'(an_n), 16'(6'b011111)); chk("e53_seg", 16'(seg_n), 16'(7'b0010010));
    adv(10); chk("e63_an", 16'(an_n), 16'(6'b111110));

    // Mid-frame input change (digit 3 slot) must wait for the next snapshot.
    adv(32);
    in_d[0] = 7'b1111001;
    adv(18); chk("e113_seg", 16'(seg_n), 16'(7'b0010010));
    adv(10); chk("e123_seg_new", 16'(seg_n), 16'(7'b1111001));

    // Drop enable in the digit 2 SHOW slot, then resume.
    adv(21);
    chk("e144_an", 16'(an_n), 16'(6'b111011));
    enable = 1'b0;
    adv(1); chk("dis_an", 16'(an_n), 16'h3f); chk("dis_seg", 16'(seg_n), 16'h7f);
    chk("dis_dp", 16'(dp_n), 16'(1));
    in_d[0] = 7'b0100100;
    adv(3);
    enable = 1'b1;
    adv(1); chk("re1_an", 16'(an_n), 16'h3f);
    enable = 1'b0;
    adv(1); chk("snap_vs_dis_tick", 16'(frame_tick), 16'(0));
    enable = 1'b1;
    adv(2); chk("re_tick", 16'(frame_tick), 16'(1));
    adv(1); chk("re_an", 16'(an_n), 16'(6'b111110)); chk("re_seg", 16'(seg_n), 16'(7'b0100100));

    // Asynchronous reset mid-slot.
    adv(2);
    #2 reset_n = 1'b0;
    #1 chk("arst_an", 16'(an_n), 16'h3f); chk("arst_seg", 16'(seg_n), 16'h7f);
    chk("arst_tick", 16'(frame_tick), 16'(0));
    @(negedge clk); reset_n = 1'b1;

    // Randomized inputs and enable drops over more than 10 frames.
    hold = 0;
    repeat (720) begin
      adv(1);
      if ($urandom_range(0, 5) == 0) in_d[$urandom_range(0, 5)] = 7'($urandom);
      if (hold > 0) begin
        hold--;
        if (hold == 0) enable = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        enable = 1'b0;
        hold = $urandom_range(1, 15);
      end
    end
    enable = 1'b1;

    // Leading-zero digits.
    set_pattern();
    in_d[5] = ZERO; in_d[4] = ZERO;
    restart();
    watch_lead(2 * FRAME, s4, s5);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_an4_off", 16'(s4), 16'(0)); chk("lz_an5_off", 16'(s5), 16'(0));
`else
    chk("lz_an4_on", 16'(s4), 16'(1)); chk("lz_an5_on", 16'(s5), 16'(1));
`endif
    in_d[4] = 7'b1111001;
    restart();
    watch_lead(2 * FRAME, s4, s5);
    chk("lz_an4_shown", 16'(s4), 16'(1));
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_an5_still_off", 16'(s5), 16'(0));
`else
    chk("lz_an5_shown", 16'(s5), 16'(1));
`endif

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Consumer end of the stopwatch seven-segment outputs. Takes the six per-digit active-low segment patterns and drives one time-multiplexed 6-digit common-anode display: shared segment bus plus per-digit anode enables, with a blanking gap between digits to suppress ghosting. Patterns are snapshotted once per frame so the display never tears.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
DIGIT_HZ, 1000, per-digit slot rate; DWELL_CYCLES = CLK_HZ/DIGIT_HZ cycles per slot
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < DWELL_CYCLES, otherwise elaboration error
DP_MASK, 6'b010100, per-digit decimal point enable (bit i = digit i); default lights dp after one_min and one_sec

Ports:
CLK_50MHz  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  display enable; low = all anodes off
hundredths_seven_seg  in  7  digit 0 pattern {g,f,e,d,c,b,a}, active low
tenths_seven_seg  in  7  digit 1 pattern
one_sec_seven_seg  in  7  digit 2 pattern
ten_secs_seven_seg  in  7  digit 3 pattern
one_min_seven_seg  in  7  digit 4 pattern
ten_mins_seven_seg  in  7  digit 5 pattern
seg_n  out  7  shared segment bus, active low
dp_n  out  1  shared decimal point, active low
an_n  out  6  anode enables, active low, one-hot-low or all high
frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Clocking and reset: one clock, CLK_50MHz. reset_n is asynchronous and active-low. During reset and on release: an_n=6'b111111, seg_n=7'b1111111, dp_n=1, frame_tick=0, state=BLANK, digit=0, cnt=0, shadow patterns=7'b1111111.
- FSM has two states, BLANK and SHOW. cnt is a slot cycle counter.
- BLANK: an_n all high. After BLANK_CYCLES cycles (cnt == BLANK_CYCLES-1), go to SHOW and clear cnt.
- SHOW: lasts DWELL_CYCLES-BLANK_CYCLES cycles. On its last cycle, go to BLANK and advance digit 0->1->...->5->0 (wrap).
- Slot length: every slot is exactly DWELL_CYCLES; a frame is 6*DWELL_CYCLES.
- Snapshot: on the BLANK->SHOW transition with digit==0, all six inputs load into the shadow registers and frame_tick=1 for that single cycle. Input changes at any other time do not affect the frame in progress.
- Registered outputs: in every SHOW cycle, an_n[digit]=0 (all other anodes high), seg_n=shadow[digit], dp_n=~DP_MASK[digit]. In BLANK, seg_n=7'b1111111 and dp_n=1. Outputs change on the clock edge after the state change (1-cycle latency).
- enable low: on the next edge, forces BLANK with cnt=0 and digit=0, all outputs off, frame_tick=0. Shadow registers keep their values.
- enable re-asserted: resumes with a full BLANK slot at digit 0. The first SHOW then takes a fresh snapshot.
- enable deasserted on the same edge as a snapshot: enable wins; no snapshot and no frame_tick.
- Asynchronous reset mid-slot: immediate return to reset values.
- Invariant: at most one an_n bit is low at any time.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: the digit 5 anode stays high during its SHOW slot if shadow[5]==SEG_ZERO. The digit 4 anode is likewise suppressed if shadow[5] and shadow[4] both equal SEG_ZERO. dp_n is also held at 1 for a suppressed digit. Slot timing is unchanged. Digits 0-3 are never suppressed.
- Undefined: all six digits are always shown.

Decomposition:
- Package seven_seg_pkg: SEG_ZERO=7'b1000000, SEG_OFF=7'b1111111, NUM_DIGITS=6, digit index constants DIG_HUNDREDTHS..DIG_TEN_MINS, the state enum {BLANK, SHOW}.
- Sub-module scan_slot_timer holds the FSM, cnt and digit counter, and outputs state, digit and snapshot strobe. The top level holds the shadow registers, output mux and optional blanking.

Test Plan (CLK_HZ=1000, DIGIT_HZ=100 -> DWELL=10, BLANK_CYCLES=2):
- Reset release, enable=1 -> an_n=111111 for 2 cycles; then an_n=111110 for 8 cycles; slot pattern repeats per digit; an_n=011111 at cycle 52; frame period 60 cycles.
- Inputs 7'b1000000,7'b1111001,7'b0100100,7'b0110000,7'b0011001,7'b0010010 (0..5) -> seg_n matches the corresponding digit's pattern in each SHOW slot; dp_n=0 only in the digit 2 and digit 4 slots.
- Change hundredths input mid-frame (during the digit 3 slot) -> seg_n for the remaining slots is unchanged; the new value appears only after the next frame_tick.
- Drop enable during the digit 2 SHOW slot -> next cycle an_n=111111, seg_n=1111111; re-assert -> 2 blank cycles, then digit 0 shown with a fresh snapshot and frame_tick=1.
- With LEADING_ZERO_BLANK_EN, ten_mins=one_min=SEG_ZERO -> an_n bits 5 and 4 never go low; set one_min=7'b1111001 -> digit 4 is shown and digit 5 stays blanked.
- Over 10 frames, check every cycle that popcount(~an_n)<=1 -> never violated.
